coriolis_ker0_join2: RTL and testbench
======================================

Name: coriolis_ker0_join2

Overview:
- Operand-alignment join stage directly downstream of the constant-multiply leaf (34-bit FloPoCo stream, 3-cycle latency).
- Buffers the multiply result and a parallel branch stream (e.g. the pass-through operand) in two small FWFT FIFOs.
- Presents them as one aligned operand pair, with a single valid/ready handshake, to the following two-input FP adder leaf.
- Absorbs latency mismatch and back-pressure so neither branch stalls the other needlessly.

Parameters:
- STREAMW, 34, operand width: 2-bit FloPoCo exception field + 32-bit IEEE single. Data is passed unmodified.
- DEPTH, 4, entries per input FIFO. Must be a power of 2, ≥2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (rst==0 resets on rising clk)
- ivalid_in1  in  1  in1 data valid (from mul1 ovalid)
- in1  in  STREAMW  operand 1 (mul1 out1)
- iready_in1  out  1  FIFO1 can accept
- ivalid_in2  in  1  in2 data valid (parallel branch)
- in2  in  STREAMW  operand 2
- iready_in2  out  1  FIFO2 can accept
- ovalid  out  1  aligned pair available
- out1  out  STREAMW  FIFO1 head
- out2  out  STREAMW  FIFO2 head
- oready  in  1  downstream adder ready
- cnt1  out  AW+1  FIFO1 occupancy
- cnt2  out  AW+1  FIFO2 occupancy

Behaviour:
- Reset (rst==0 at clk edge):
  - Pointers and counts cleared: cnt1=cnt2=0, ovalid=0, iready_in1=iready_in2=1 after the edge.
  - out1/out2 are don't-care while empty; implementation drives 0.
  - Reset mid-operation discards all stored entries; no partial pair survives.
- Each FIFO is a circular buffer with wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH) and count (AW+1 bits, 0..DEPTH).
- Push k = ivalid_ink & iready_ink. Write at wr_ptr, then wr_ptr+1.
- iready_ink = (cntk != DEPTH). It is registered state only, with no combinational path from oready.
- ovalid = (cnt1 != 0) & (cnt2 != 0). It is combinational from registered counts.
- Pop = ovalid & oready. Both FIFOs pop together in the same cycle; rd_ptr+1 on each.
- out1/out2 = mem[rd_ptr] (first-word fall-through). A pushed word appears on the outputs the cycle after the push: latency 1 clk when empty.
- Count update per FIFO: push&!pop → +1; pop&!push → −1; push&pop → unchanged; neither → unchanged.
- Full FIFO with simultaneous pop: iready is low, so no push that cycle. The slot frees the next cycle (no bypass).
- Empty FIFO: a push does not make ovalid high in the same cycle (no write-through).
- One side empty, other side non-empty: ovalid=0. The non-empty side keeps accepting until full, then deasserts its iready.
- ivalid_ink with iready_ink=0: the word is not consumed. The upstream holds the data; no error state.
- Order is preserved per input. The Nth word of in1 is always paired with the Nth word of in2.
- Data is never inspected. Exception bits and NaN/Inf patterns pass through unchanged.
- Throughput: 1 pair/clk sustained when both inputs stream and oready=1.

Test Plan:
- Reset/idle: hold rst=0 for 2 clk, then release → cnt1=cnt2=0, ovalid=0, iready_in1=iready_in2=1.
- Alignment: push in1={2'b01,32'h3F800000} at cycle 0 and in2={2'b01,32'h40000000} at cycle 3, oready=1 → ovalid rises cycle 4 with out1=34'h13F800000, out2=34'h140000000. Pop at cycle 4; cnt back to 0 at cycle 5.
- Fill/full: push 4 words to in1 only (values 1..4), in2 idle → cnt1=4, iready_in1=0, ovalid=0. Then push in2 values A..D with oready=1 → pairs (1,A),(2,B),(3,C),(4,D) in order; iready_in1 returns to 1 the cycle after the first pop.
- Back-pressure: both streams continuous with oready=0 → both FIFOs fill to 4, both ireadys drop, data held. Release oready → 4 pairs emitted on 4 consecutive clocks, no loss or duplication.
- Simultaneous push+pop: cnt1=2, cnt2=2, push both with oready=1 → counts stay 2; pointers wrap correctly over 20 cycles; output sequence matches input order.
- Reset mid-stream: cnt1=3 at rst=0 → next cycle cnt1=0, ovalid=0; subsequent pushes pair from fresh data only.

Source files
------------

// File: rtl/coriolis_ker0_join2.sv
// coriolis_ker0_join2: aligns two operand streams through paired FWFT FIFOs
// and hands them downstream as one valid/ready pair.
module coriolis_ker0_join2 #(
  parameter int STREAMW = 34,
  parameter int DEPTH   = 4,
  parameter int AW      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid_in1,
  input  logic [STREAMW-1:0] in1,
  output logic               iready_in1,
  input  logic               ivalid_in2,
  input  logic [STREAMW-1:0] in2,
  output logic               iready_in2,
  output logic               ovalid,
  output logic [STREAMW-1:0] out1,
  output logic [STREAMW-1:0] out2,
  input  logic               oready,
  output logic [AW:0]        cnt1,
  output logic [AW:0]        cnt2
);
  logic [STREAMW-1:0] mem1 [DEPTH];
  logic [STREAMW-1:0] mem2 [DEPTH];
  logic [AW-1:0] wp1, rp1, wp2, rp2;
  logic push1, push2, pop;
  assign iready_in1 = cnt1 != (AW+1)'(DEPTH);
  assign iready_in2 = cnt2 != (AW+1)'(DEPTH);
  assign ovalid = (cnt1 != '0) && (cnt2 != '0);
  assign push1 = ivalid_in1 & iready_in1;
  assign push2 = ivalid_in2 & iready_in2;
  assign pop = ovalid & oready;
  assign out1 = cnt1 != '0 ? mem1[rp1] : '0;
  assign out2 = cnt2 != '0 ? mem2[rp2] : '0;
  always_ff @(posedge clk) begin
    if (push1) mem1[wp1] <= in1;
    if (push2) mem2[wp2] <= in2;
  end
  // push and pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp1 <= '0;
      rp1 <= '0;
      wp2 <= '0;
      rp2 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (push1) wp1 <= wp1 + 1'b1;
      if (push2) wp2 <= wp2 + 1'b1;
      if (pop) rp1 <= rp1 + 1'b1;
      if (pop) rp2 <= rp2 + 1'b1;
      cnt1 <= cnt1 + (AW+1)'(push1) - (AW+1)'(pop);
      cnt2 <= cnt2 + (AW+1)'(push2) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_coriolis_ker0_join2.sv
// tb_coriolis_ker0_join2: directed self-checking bench for the operand join.
module tb_coriolis_ker0_join2;
  logic clk = 0, rst = 0;
  logic ivalid_in1 = 0, ivalid_in2 = 0, oready = 0;
  logic [33:0] in1 = '0, in2 = '0;
  logic iready_in1, iready_in2, ovalid;
  logic [33:0] out1, out2;
  logic [2:0] cnt1, cnt2;
  int n_assert = 0, n_fail = 0;

  coriolis_ker0_join2 dut (
    .clk(clk), .rst(rst),
    .ivalid_in1(ivalid_in1), .in1(in1), .iready_in1(iready_in1),
    .ivalid_in2(ivalid_in2), .in2(in2), .iready_in2(iready_in2),
    .ovalid(ovalid), .out1(out1), .out2(out2), .oready(oready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick;
    tick;
    rst = 1;
    chk("rst_cnt1", cnt1, 0);
    chk("rst_cnt2", cnt2, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_iready1", iready_in1, 1);
    chk("rst_iready2", iready_in2, 1);
    chk("rst_out1", out1, 0);

    ivalid_in1 = 1; in1 = 34'h13F800000;
    tick;
    ivalid_in1 = 0; oready = 1;
    chk("al_cnt1", cnt1, 1);
    chk("al_ov_one_side", ovalid, 0);
    tick;
    tick;
    ivalid_in2 = 1; in2 = 34'h140000000;
    chk("al_no_writethru", ovalid, 0);
    tick;
    ivalid_in2 = 0;
    chk("al_ovalid", ovalid, 1);
    chk("al_out1", out1, 34'h13F800000);
    chk("al_out2", out2, 34'h140000000);
    tick;
    chk("al_cnt1_0", cnt1, 0);
    chk("al_cnt2_0", cnt2, 0);
    chk("al_ov_0", ovalid, 0);

    oready = 0;
    for (int i = 1; i <= 4; i++) begin
      ivalid_in1 = 1; in1 = 34'(i);
      tick;
    end
    chk("fill_cnt1", cnt1, 4);
    chk("fill_iready1", iready_in1, 0);
    chk("fill_ovalid", ovalid, 0);
    in1 = 34'h99;
    tick;
    ivalid_in1 = 0;
    chk("full_hold_cnt1", cnt1, 4);
    oready = 1;
    for (int j = 0; j < 4; j++) begin
      ivalid_in2 = 1; in2 = 34'hA + 34'(j);
      tick;
      chk("fill_ov", ovalid, 1);
      chk("fill_out1", out1, 34'(j + 1));
      chk("fill_out2", out2, 34'hA + 34'(j));
      chk("fill_cnt1_run", cnt1, j == 0 ? 4 : 4 - j);
      chk("fill_iready1_run", iready_in1, j == 0 ? 0 : 1);
    end
    ivalid_in2 = 0;
    tick;
    chk("fill_drain_cnt1", cnt1, 0);
    chk("fill_drain_cnt2", cnt2, 0);

    oready = 0;
    for (int i = 0; i < 4; i++) begin
      ivalid_in1 = 1; ivalid_in2 = 1;
      in1 = 34'h100 + 34'(i); in2 = 34'h200 + 34'(i);
      tick;
    end
    in1 = 34'h1FF; in2 = 34'h2FF;
    tick;
    tick;
    chk("bp_cnt1", cnt1, 4);
    chk("bp_cnt2", cnt2, 4);
    chk("bp_iready1", iready_in1, 0);
    chk("bp_iready2", iready_in2, 0);
    ivalid_in1 = 0; ivalid_in2 = 0; oready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ov", ovalid, 1);
      chk("bp_out1", out1, 34'h100 + 34'(i));
      chk("bp_out2", out2, 34'h200 + 34'(i));
      tick;
    end
    chk("bp_empty_ov", ovalid, 0);
    chk("bp_empty_cnt1", cnt1, 0);

    oready = 0;
    for (int i = 0; i < 2; i++) begin
      ivalid_in1 = 1; ivalid_in2 = 1;
      in1 = 34'h300 + 34'(i); in2 = 34'h400 + 34'(i);
      tick;
    end
    chk("sp_cnt1", cnt1, 2);
    chk("sp_cnt2", cnt2, 2);
    oready = 1;
    for (int i = 0; i < 20; i++) begin
      in1 = 34'h302 + 34'(i); in2 = 34'h402 + 34'(i);
      chk("sp_out1", out1, 34'h300 + 34'(i));
      chk("sp_out2", out2, 34'h400 + 34'(i));
      tick;
      chk("sp_cnt1_run", cnt1, 2);
      chk("sp_cnt2_run", cnt2, 2);
    end
    ivalid_in1 = 0; ivalid_in2 = 0;
    for (int i = 20; i < 22; i++) begin
      chk("sp_tail1", out1, 34'h300 + 34'(i));
      chk("sp_tail2", out2, 34'h400 + 34'(i));
      tick;
    end
    chk("sp_end_cnt1", cnt1, 0);

    oready = 0;
    for (int i = 0; i < 3; i++) begin
      ivalid_in1 = 1; in1 = 34'h500 + 34'(i);
      tick;
    end
    ivalid_in1 = 0;
    chk("mr_cnt1", cnt1, 3);
    rst = 0;
    tick;
    rst = 1;
    chk("mr_cnt1_0", cnt1, 0);
    chk("mr_ov", ovalid, 0);
    chk("mr_iready1", iready_in1, 1);
    ivalid_in1 = 1; ivalid_in2 = 1; in1 = 34'h600; in2 = 34'h700;
    tick;
    ivalid_in1 = 0; ivalid_in2 = 0;
    chk("mr_ov_new", ovalid, 1);
    chk("mr_out1", out1, 34'h600);
    chk("mr_out2", out2, 34'h700);
    oready = 1;
    tick;
    chk("mr_end_cnt1", cnt1, 0);
    chk("mr_end_cnt2", cnt2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
